// File: rtl/pipe_stage_buffer.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_buffer #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam bit HasSkid = (SKID != 0);
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e state;

    logic              main_vld_q, main_vld_d;
    logic [DATA_W-1:0] main_q,     main_d;
    logic              skid_vld_q, skid_vld_d;
    logic [DATA_W-1:0] skid_q,     skid_d;
    logic              rdy_q,      rdy_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;

    logic push;
    logic pop;

    // Skid mode drives ready from a flop; single-entry mode passes ready_in.
    assign ready_out = HasSkid ? rdy_q : (!main_vld_q || ready_in);
    assign valid_out = main_vld_q;
    assign data_out  = main_q;
    assign stall_cnt = cnt_q;
    assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

    assign push = valid_in && ready_out;
    assign pop  = main_vld_q && ready_in;

    // Occupancy state is a pure decode of the two valid bits.
    always_comb begin
        state = EMPTY;
        if (skid_vld_q) begin
            state = FULL;
        end else if (main_vld_q) begin
            state = ONE;
        end
    end

    // Next-state for storage; flush overrides every transition.
    always_comb begin
        main_vld_d = main_vld_q;
        main_d     = main_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (flush) begin
            main_vld_d = 1'b0;
            main_d     = '0;
            skid_vld_d = 1'b0;
            skid_d     = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        main_vld_d = 1'b1;
                        main_d     = data_in;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = data_in;
                    end else if (push && HasSkid) begin
                        skid_vld_d = 1'b1;
                        skid_d     = data_in;
                    end else if (pop) begin
                        main_vld_d = 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d     = skid_q;
                        skid_vld_d = 1'b0;
                    end
                end
                default: begin
                    main_vld_d = main_vld_q;
                end
            endcase
        end
    end

    // Registered ready follows the skid slot being free after the edge.
    always_comb begin
        rdy_d = 1'b1;
        if (HasSkid) begin
            rdy_d = !skid_vld_d;
        end
    end

    // Stall counter saturates at all-ones; only reset clears it.
    always_comb begin
        cnt_d = cnt_q;
        if (main_vld_q && !ready_in && (cnt_q != '1)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            main_q     <= '0;
            skid_vld_q <= 1'b0;
            skid_q     <= '0;
            rdy_q      <= 1'b1;
            cnt_q      <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_q     <= main_d;
            skid_vld_q <= skid_vld_d;
            skid_q     <= skid_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Randomised and directed bench for pipe_stage_buffer: three instances
// (skid, no-skid, skid with 2-bit counter) against a FIFO-level model.
module tb_pipe_stage_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in;
    logic       ready_in;
    logic       flush;
    logic [7:0] data_in;

    logic [2:0] vld;
    logic [2:0] rdy;
    logic [7:0] dout [3];
    logic [1:0] occ  [3];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int vectors     = 0;
    int miscompares = 0;

    bit         skid_m [3] = '{1'b1, 1'b0, 1'b1};
    int         cmax   [3] = '{65535, 65535, 3};
    logic [7:0] mem    [3][2];
    int         n      [3];
    int         cnt_m  [3];
    bit         zf     [3];

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_W(8), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(rdy[0]),
        .data_in(data_in), .valid_out(vld[0]), .ready_in(ready_in),
        .data_out(dout[0]), .flush(flush), .occupancy(occ[0]),
        .stall_cnt(cnt0)
    );

    pipe_stage_buffer #(.DATA_W(8), .SKID(0), .CNT_W(16)) u_noskid (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(rdy[1]),
        .data_in(data_in), .valid_out(vld[1]), .ready_in(ready_in),
        .data_out(dout[1]), .flush(flush), .occupancy(occ[1]),
        .stall_cnt(cnt1)
    );

    pipe_stage_buffer #(.DATA_W(8), .SKID(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(rdy[2]),
        .data_in(data_in), .valid_out(vld[2]), .ready_in(ready_in),
        .data_out(dout[2]), .flush(flush), .occupancy(occ[2]),
        .stall_cnt(cnt2)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cnt_of(input int k);
        if (k == 0) return 64'(cnt0);
        if (k == 1) return 64'(cnt1);
        return 64'(cnt2);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            n[k]      = 0;
            cnt_m[k]  = 0;
            zf[k]     = 1'b1;
            mem[k][0] = '0;
            mem[k][1] = '0;
        end
    endtask

    task automatic cycle();
        bit push [3];
        bit pop  [3];
        bit r;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (skid_m[k]) r = (n[k] < 2);
            else           r = (n[k] == 0) || ready_in;
            check($sformatf("valid_out%0d", k), 64'(vld[k]), 64'(n[k] > 0));
            check($sformatf("ready_out%0d", k), 64'(rdy[k]), 64'(r));
            check($sformatf("occupancy%0d", k), 64'(occ[k]), 64'(n[k]));
            check($sformatf("stall_cnt%0d", k), cnt_of(k), 64'(cnt_m[k]));
            if (n[k] > 0)
                check($sformatf("data_out%0d", k), 64'(dout[k]),
                      64'(mem[k][0]));
            else if (zf[k])
                check($sformatf("data_zero%0d", k), 64'(dout[k]), 64'd0);
            push[k] = valid_in && r;
            pop[k]  = (n[k] > 0) && ready_in;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                n[k] = 0; cnt_m[k] = 0; zf[k] = 1'b1;
            end else begin
                if ((n[k] > 0) && !ready_in && (cnt_m[k] < cmax[k]))
                    cnt_m[k]++;
                if (flush) begin
                    n[k]  = 0;
                    zf[k] = 1'b1;
                end else begin
                    if (pop[k]) begin
                        mem[k][0] = mem[k][1];
                        n[k]--;
                    end
                    if (push[k]) begin
                        mem[k][n[k]] = data_in;
                        n[k]++;
                        zf[k] = 1'b0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit r,
                         input bit f);
        valid_in = v;
        data_in  = d;
        ready_in = r;
        flush    = f;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
        flush = 1'b0; data_in = '0;
        model_reset();
        #1;
        repeat (4) begin
            drive(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end
        rst = 1'b0;

        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b1, 1'b0);

        drive(1'b1, 8'hA0, 1'b0, 1'b0);
        drive(1'b1, 8'hB0, 1'b0, 1'b0);
        drive(1'b1, 8'hC0, 1'b0, 1'b0);
        drive(1'b1, 8'hC0, 1'b0, 1'b0);
        repeat (2) drive(1'b1, 8'hC0, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

        drive(1'b1, 8'h55, 1'b0, 1'b0);
        repeat (6) drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'hA1, 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h66, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        valid_in = 1'b1; data_in = 8'h33;
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("async_valid%0d", k), 64'(vld[k]), 64'd0);
            check($sformatf("async_ready%0d", k), 64'(rdy[k]), 64'd1);
            check($sformatf("async_occ%0d", k), 64'(occ[k]), 64'd0);
            check($sformatf("async_data%0d", k), 64'(dout[k]), 64'd0);
            check($sformatf("async_cnt%0d", k), cnt_of(k), 64'd0);
        end
        model_reset();
        cycle();
        rst = 1'b0;

        repeat (3000) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
